// File: rtl/bexkat1Def_pkg.sv
// Shared definitions for the memory stage: instruction types, access widths, FSM states.
// Latency: none (package).
// Backpressure: none (package).
package bexkat1Def;

  // Instruction type field, ir[31:28]
  localparam logic [3:0] T_INH   = 4'h0;
  localparam logic [3:0] T_ALU   = 4'h1;
  localparam logic [3:0] T_LOAD  = 4'h2;
  localparam logic [3:0] T_STORE = 4'h3;
  localparam logic [3:0] T_JUMP  = 4'h4;

  // Access width, taken from ir_op[1:0]; the spare code behaves as a word access
  typedef enum logic [1:0] {
    W_WORD     = 2'd0,
    W_HALF     = 2'd1,
    W_BYTE     = 2'd2,
    W_WORD_ALT = 2'd3
  } width_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Last count value at which a bus cycle may still be acknowledged
  localparam logic [7:0] TMO_LIMIT = 8'hff;

  function automatic logic is_mem_type(input logic [3:0] t);
    return (t == T_LOAD) || (t == T_STORE);
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane logic: select generation, store-data replication, load extraction (big-endian lanes).
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_lane
  import bexkat1Def::*;
(
  input  width_t      width,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  sel,
  output logic [31:0] st_word,
  output logic [31:0] ld_data
);

  // Lane 3 holds bits [31:24] and corresponds to byte offset 0
  always_comb begin
    sel     = 4'hf;
    st_word = st_data;
    ld_data = rd_word;
    case (width)
      W_HALF: begin
        sel     = addr_lo[1] ? 4'h3 : 4'hc;
        st_word = {2{st_data[15:0]}};
        ld_data = {16'h0, (addr_lo[1] ? rd_word[15:0] : rd_word[31:16])};
      end
      W_BYTE: begin
        sel     = 4'b1000 >> addr_lo;
        st_word = {4{st_data[7:0]}};
        case (addr_lo)
          2'd0:    ld_data = {24'h0, rd_word[31:24]};
          2'd1:    ld_data = {24'h0, rd_word[23:16]};
          2'd2:    ld_data = {24'h0, rd_word[15:8]};
          default: ld_data = {24'h0, rd_word[7:0]};
        endcase
      end
      default: begin
        sel     = 4'hf;
        st_word = st_data;
        ld_data = rd_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory pipeline stage: passes non-memory ops through, runs one bus cycle per load/store.
// Latency: 1 cycle for non-memory ops; memory ops take entry + BUS cycles + 1 DONE cycle.
// Backpressure: stall_o holds the execute stage while a bus cycle is pending; 256-cycle bus timeout.
module mem_access
  import bexkat1Def::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] ir_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] result_i,
  input  logic [31:0] reg_data1_i,
  input  logic [1:0]  reg_write_i,
  output logic        stall_o,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o,
  output logic [31:0] result_o,
  output logic [1:0]  reg_write_o,
  output logic        bus_cyc_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  output logic        fault_o
);

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic [31:0] ld_q;

  logic [3:0]  ir_type;
  width_t      width;
  logic        mem_req;
  logic        tmo_hit;
  logic [3:0]  lane_sel;
  logic [31:0] lane_st;
  logic [31:0] lane_ld;

  assign ir_type = ir_i[31:28];
  assign width   = width_t'(ir_i[25:24]);
  assign mem_req = is_mem_type(ir_type);
  // An ack on the last allowed count wins over the timeout
  assign tmo_hit = (state == S_BUS) && !bus_ack_i && (tmo_cnt == TMO_LIMIT);

  // Stall must act in the same cycle the memory op is seen; it drops on the timeout
  // cycle so the execute stage moves past the faulting instruction.
  assign stall_o = rst_i && (((state == S_IDLE) && mem_req) ||
                             ((state == S_BUS) && !tmo_hit));

  mem_lane u_lane (
    .width   (width),
    .addr_lo (result_i[1:0]),
    .st_data (reg_data1_i),
    .rd_word (bus_dat_i),
    .sel     (lane_sel),
    .st_word (lane_st),
    .ld_data (lane_ld)
  );

  // Memory-stage FSM with all outputs registered
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      tmo_cnt     <= 8'h0;
      ld_q        <= 32'h0;
      ir_o        <= 64'h0;
      pc_o        <= 32'h0;
      result_o    <= 32'h0;
      reg_write_o <= 2'h0;
      bus_cyc_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_adr_o   <= 32'h0;
      bus_sel_o   <= 4'h0;
      bus_dat_o   <= 32'h0;
      fault_o     <= 1'b0;
    end else begin
      fault_o <= 1'b0;
      case (state)
        S_IDLE: begin
          pc_o     <= pc_i;
          result_o <= result_i;
          if (mem_req) begin
            ir_o        <= 64'h0;
            reg_write_o <= 2'h0;
            bus_cyc_o   <= 1'b1;
            bus_we_o    <= (ir_type == T_STORE);
            bus_adr_o   <= {result_i[31:2], 2'b00};
            bus_sel_o   <= lane_sel;
            bus_dat_o   <= lane_st;
            tmo_cnt     <= 8'h0;
            state       <= S_BUS;
          end else begin
            ir_o        <= ir_i;
            reg_write_o <= reg_write_i;
          end
        end
        S_BUS: begin
          if (bus_ack_i) begin
            ld_q      <= lane_ld;
            bus_cyc_o <= 1'b0;
            bus_we_o  <= 1'b0;
            state     <= S_DONE;
          end else if (tmo_hit) begin
            fault_o     <= 1'b1;
            bus_cyc_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            ir_o        <= 64'h0;
            reg_write_o <= 2'h0;
            state       <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'h1;
          end
        end
        S_DONE: begin
          ir_o        <= ir_i;
          pc_o        <= pc_i;
          reg_write_o <= reg_write_i;
          result_o    <= (ir_type == T_LOAD) ? ld_q : result_i;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
